span_scan_risk_engine: RTL and testbench

SPAN_SCAN_RISK_ENGINE -- requirements
Module: span_scan_risk_engine

---
 rtl/span_scan_risk_engine.sv | 153 +++++++++++++++
 tb/tb_span_scan_risk_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/span_scan_risk_engine.sv
// Span-style scanning risk: net the positions, scan 8 price scenarios, report the worst loss.
// Optional macro SCAN_RISK_ROUND_EN selects round-half-up instead of truncation of the result.
module span_scan_risk_engine #(
  parameter int N_POS  = 8,
  parameter int POS_W  = 16,
  parameter int PSR_W  = 16,
  parameter int RISK_W = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PSR_W-1:0]            price_scan_range,
  input  logic [N_POS-1:0][POS_W-1:0] position,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [RISK_W-1:0]           scanning_risk,
  output logic [2:0]                  worst_idx
);

  localparam int CNT_W  = $clog2(N_POS);
  localparam int NET_W  = POS_W + CNT_W;
  localparam int LOSS_W = 9 + (PSR_W + 1) + NET_W;
  localparam int EXT_W  = ((LOSS_W > RISK_W) ? LOSS_W : RISK_W) + 1;

  typedef enum logic [1:0] {IDLE, ACC, SCAN, DONE} state_t;

  state_t                      state_q;
  logic [N_POS-1:0][POS_W-1:0] pos_q;
  logic [PSR_W-1:0]            psr_q;
  logic [CNT_W-1:0]            idx_q;
  logic [2:0]                  k_q;
  logic signed [NET_W-1:0]     net_q;
  logic signed [LOSS_W-1:0]    max_q;
  logic [2:0]                  best_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic [RISK_W-1:0]           risk_q;
  logic [2:0]                  widx_q;

  function automatic logic signed [8:0] scen_mult(input logic [2:0] k);
    logic signed [8:0] m;
    m = 9'sd0;
    case (k)
      3'd0: m =  9'sd43;
      3'd1: m = -9'sd43;
      3'd2: m =  9'sd85;
      3'd3: m = -9'sd85;
      3'd4: m =  9'sd128;
      3'd5: m = -9'sd128;
      3'd6: m =  9'sd134;
      default: m = -9'sd134;
    endcase
    return m;
  endfunction

  logic signed [NET_W-1:0]  pos_ext;
  logic signed [NET_W-1:0]  net_d;
  logic signed [LOSS_W-1:0] m_ext, p_ext, n_ext;
  logic signed [LOSS_W-1:0] loss;
  logic signed [LOSS_W-1:0] max_d;
  logic [2:0]               best_d;
  logic                     upd;
  logic [EXT_W-1:0]         max_ext;
  logic [EXT_W-1:0]         res_ext;
  logic [RISK_W-1:0]        risk_d;

  always_comb begin
    pos_ext = {{(NET_W-POS_W){pos_q[idx_q][POS_W-1]}}, pos_q[idx_q]};
    net_d   = net_q + pos_ext;
    m_ext   = LOSS_W'(scen_mult(k_q));
    p_ext   = LOSS_W'($signed({1'b0, psr_q}));
    n_ext   = LOSS_W'(net_q);
    // LOSS_W leaves headroom so the triple product and its negation never wrap.
    loss    = -(m_ext * p_ext * n_ext);
    upd     = loss > max_q;
    max_d   = upd ? loss : max_q;
    best_d  = upd ? k_q : best_q;
    max_ext = EXT_W'($unsigned(max_d));
`ifdef SCAN_RISK_ROUND_EN
    res_ext = (max_ext + EXT_W'(64)) >> 7;
`else
    res_ext = max_ext >> 7;
`endif
    risk_d  = (res_ext > EXT_W'({RISK_W{1'b1}})) ? {RISK_W{1'b1}} : res_ext[RISK_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      psr_q       <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      net_q       <= '0;
      max_q       <= '0;
      best_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      risk_q      <= '0;
      widx_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            pos_q      <= position;
            psr_q      <= price_scan_range;
            net_q      <= '0;
            max_q      <= '0;
            best_q     <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACC;
          end
        end
        ACC: begin
          net_q <= net_d;
          if (idx_q == CNT_W'(N_POS - 1)) begin
            k_q     <= '0;
            state_q <= SCAN;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        SCAN: begin
          max_q  <= max_d;
          best_q <= best_d;
          k_q    <= k_q + 1'b1;
          if (k_q == 3'd7) begin
            risk_q      <= risk_d;
            widx_q      <= best_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: begin
          // New requests only open up the cycle after consumption.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign scanning_risk = risk_q;
  assign worst_idx     = widx_q;

endmodule

// File: tb/tb_span_scan_risk_engine.sv
// Scoreboard bench for span_scan_risk_engine at default parameters.
module tb_span_scan_risk_engine;

  localparam int N   = 8;
  localparam int PW  = 16;
  localparam int SW  = 16;
  localparam int RW  = 32;
  localparam int LAT = 16;
`ifdef SCAN_RISK_ROUND_EN
  localparam longint R837 = 838;
`else
  localparam longint R837 = 837;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [SW-1:0]        price_scan_range;
  logic [N-1:0][PW-1:0] position;
  logic                 out_valid;
  logic                 out_ready;
  logic [RW-1:0]        scanning_risk;
  logic [2:0]           worst_idx;

  always #5 clk = ~clk;

  span_scan_risk_engine dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .price_scan_range(price_scan_range), .position(position),
    .out_valid(out_valid), .out_ready(out_ready),
    .scanning_risk(scanning_risk), .worst_idx(worst_idx)
  );

  typedef struct { longint risk; int idx; int acc; } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model(input logic [SW-1:0] psr, input logic [N-1:0][PW-1:0] p,
                       output longint risk, output int widx);
    longint net, mx, l;
    int m[8];
    m = '{43, -43, 85, -85, 128, -128, 134, -134};
    net = 0;
    mx = 0;
    widx = 0;
    for (int i = 0; i < N; i++) net += longint'($signed(p[i]));
    for (int k = 0; k < 8; k++) begin
      l = -(longint'(m[k]) * longint'(psr) * net);
      if (l > mx) begin
        mx = l;
        widx = k;
      end
    end
`ifdef SCAN_RISK_ROUND_EN
    mx = mx + 64;
`endif
    risk = mx >>> 7;
    if (risk > 64'sh0000_0000_FFFF_FFFF) risk = 64'sh0000_0000_FFFF_FFFF;
  endtask

  task automatic send(input logic [SW-1:0] psr, input logic [N-1:0][PW-1:0] p,
                      input longint er, input int ei);
    int t;
    exp_t e;
    t = 0;
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    price_scan_range = psr;
    position = p;
    @(negedge clk);
    in_valid = 1'b0;
    price_scan_range = SW'($urandom);
    for (int i = 0; i < N; i++) position[i] = PW'($urandom);
    e.risk = er;
    e.idx = ei;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic recv(input int hold);
    int t;
    exp_t e;
    logic ok;
    t = 0;
    while (out_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      n_bad++;
      $display("FAIL recv_timeout: out_valid=%b queued=%0d, required a result", out_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    if (cyc - e.acc !== LAT) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles, required %0d", cyc - e.acc, LAT);
    end
    n_cmp++;
    if (longint'(scanning_risk) !== e.risk) begin
      n_bad++;
      $display("FAIL scanning_risk: got %0d, required %0d", scanning_risk, e.risk);
    end
    n_cmp++;
    if (int'(worst_idx) !== e.idx) begin
      n_bad++;
      $display("FAIL worst_idx: got %0d, required %0d", worst_idx, e.idx);
    end
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          longint'(scanning_risk) !== e.risk || int'(worst_idx) !== e.idx) ok = 1'b0;
    end
    if (hold > 0) begin
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL hold_stable: out_valid=%b in_ready=%b risk=%0d idx=%0d, required 1/0/%0d/%0d",
                 out_valid, in_ready, scanning_risk, worst_idx, e.risk, e.idx);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL consume: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    price_scan_range = '0;
    position = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || scanning_risk !== '0 || worst_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b risk=%0d idx=%0d, required 1/0/0/0",
               in_ready, out_valid, scanning_risk, worst_idx);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [N-1:0][PW-1:0] p;
    int v[8];
    for (int i = 0; i < N; i++) p[i] = 16'd1;
    send(16'd100, p, R837, 7);
    recv(0);
    for (int i = 0; i < N; i++) p[i] = 16'hFFFF;
    send(16'd100, p, R837, 6);
    recv(0);
    v = '{3, -3, 1, -1, 0, 0, 2, -2};
    for (int i = 0; i < N; i++) p[i] = PW'(v[i]);
    send(16'd500, p, 0, 0);
    recv(0);
    for (int i = 0; i < N; i++) p[i] = 16'd32767;
    send(16'hFFFF, p, 64'sh0000_0000_FFFF_FFFF, 7);
    recv(0);
  endtask

  task automatic test_backpressure();
    logic [N-1:0][PW-1:0] p;
    for (int i = 0; i < N; i++) p[i] = 16'd1;
    send(16'd100, p, R837, 7);
    recv(5);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL bp_queue: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [N-1:0][PW-1:0] p;
    logic quiet;
    for (int i = 0; i < N; i++) p[i] = 16'd1;
    send(16'd100, p, R837, 7);
    void'(sb.pop_back());
    repeat (N + 3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || scanning_risk !== '0 || worst_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL mid_scan_reset: out_valid=%b in_ready=%b risk=%0d idx=%0d, required 0/1/0/0",
               out_valid, in_ready, scanning_risk, worst_idx);
    end
    reset = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin
      n_bad++;
      $display("FAIL aborted_result: out_valid rose after reset, required 0");
    end
    for (int i = 0; i < N; i++) p[i] = 16'hFFFF;
    send(16'd100, p, R837, 6);
    recv(0);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0][PW-1:0] p;
    logic [SW-1:0] psr;
    longint er;
    int ei;
    for (int r = 0; r < 8; r++) begin
      psr = SW'($urandom);
      for (int i = 0; i < N; i++)
        p[i] = (r < 4) ? PW'($urandom_range(0, 400) - 200) : PW'($urandom);
      model(psr, p, er, ei);
      send(psr, p, er, ei);
      recv(r % 3);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
